// File: rtl/spi_cmd_engine.sv
// SPI command engine: parses WRITE/READ/STATUS byte frames from the SPI slave,
// owns a small byte register file and produces the next byte for the slave to shift out.
module spi_cmd_engine #(
    parameter int          ADDR_W   = 4,
    parameter logic [7:0]  ACK_BYTE = 8'hA5,
    parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
    input  logic              sclk,
    input  logic              rst_L,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              wr_pulse,
    output logic [7:0]        status
);
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        rem_q, rem_d;
    logic              is_wr_q, is_wr_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic              ovr_q, ovr_d;
    logic [4:0]        fcnt_q, fcnt_d;
    logic [7:0]        mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] ptr_inc;
    logic [7:0]        status_w;

    assign ptr_inc  = ptr_q + 1'b1;
    assign status_w = {err_q, abort_q, ovr_q, fcnt_q};

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        is_wr_d    = is_wr_q;
        wr_pulse_d = 1'b0;
        err_d      = err_q;
        abort_d    = abort_q;
        ovr_d      = ovr_q;
        fcnt_d     = fcnt_q;
        mem_we     = 1'b0;

        if (!cs_active) begin
            // Chip-select drop ends any frame; an unfinished WRITE/READ is flagged.
            state_d = S_IDLE;
            if (state_q == S_ADDR || state_q == S_LEN ||
                (state_q == S_DATA && rem_q != 8'd0)) begin
                abort_d = 1'b1;
            end
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                        state_d = S_ADDR;
                        is_wr_d = (rx_byte == OP_WRITE);
                        tx_d    = ACK_BYTE;
                    end else if (rx_byte == OP_STATUS) begin
                        state_d = S_DONE;
                        tx_d    = status_w;
                        err_d   = 1'b0;
                        abort_d = 1'b0;
                        ovr_d   = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        tx_d    = NAK_BYTE;
                        err_d   = 1'b1;
                    end
                end
                S_ADDR: begin
                    ptr_d   = rx_byte[ADDR_W-1:0];
                    state_d = S_LEN;
                    tx_d    = status_w;
                end
                S_LEN: begin
                    rem_d = rx_byte;
                    if (rx_byte == 8'd0) begin
                        state_d = S_DONE;
                        tx_d    = 8'h00;
                        if (is_wr_q) begin
                            fcnt_d = fcnt_q + 5'd1;
                        end
                    end else begin
                        state_d = S_DATA;
                        tx_d    = is_wr_q ? 8'h00 : mem_q[ptr_q];
                    end
                end
                S_DATA: begin
                    ptr_d = ptr_inc;
                    rem_d = rem_q - 8'd1;
                    if (is_wr_q) begin
                        mem_we     = 1'b1;
                        wr_pulse_d = 1'b1;
                        tx_d       = 8'h00;
                    end else begin
                        // Prefetch the following byte so the slave always has it ready.
                        tx_d = mem_q[ptr_inc];
                    end
                    if (rem_q == 8'd1) begin
                        state_d = S_DONE;
                        if (is_wr_q) begin
                            fcnt_d = fcnt_q + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    ovr_d = 1'b1;
                    tx_d  = 8'h00;
                end
                S_ERR: begin
                    tx_d = NAK_BYTE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= S_IDLE;
            tx_q       <= 8'h00;
            ptr_q      <= '0;
            rem_q      <= 8'h00;
            is_wr_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            ovr_q      <= 1'b0;
            fcnt_q     <= 5'd0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            is_wr_q    <= is_wr_d;
            wr_pulse_q <= wr_pulse_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            ovr_q      <= ovr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Register file is cleared by reset, so it is built from flops rather than RAM.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge sclk or negedge rst_L) begin
            if (!rst_L) begin
                mem_q[gi] <= 8'h00;
            end else if (mem_we && ptr_q == ADDR_W'(gi)) begin
                mem_q[gi] <= rx_byte;
            end
        end
    end

    assign rd_data  = mem_q[rd_addr];
    assign tx_byte  = tx_q;
    assign wr_pulse = wr_pulse_q;
    assign status   = status_w;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Bench for spi_cmd_engine: directed frames with literal expectations, then random
// frames checked every cycle against a byte-position model of the protocol.
module tb_spi_cmd_engine;
    logic       sclk = 1'b0;
    logic       rst_L;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_pulse;
    logic [7:0] status;

    spi_cmd_engine #(.ADDR_W(4), .ACK_BYTE(8'hA5), .NAK_BYTE(8'hEE)) dut (
        .sclk(sclk), .rst_L(rst_L), .cs_active(cs_active), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .tx_byte(tx_byte), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_pulse(wr_pulse), .status(status)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;

    // Protocol model: a frame is a list of bytes; meaning depends on position only.
    logic [7:0] m_mem [16];
    logic [7:0] m_tx;
    logic       m_wp, m_err, m_abort, m_ovr;
    logic [4:0] m_fcnt;
    int         m_pos;
    logic [7:0] m_op, m_n;
    logic [3:0] m_addr;

    function automatic logic [7:0] m_status();
        return {m_err, m_abort, m_ovr, m_fcnt};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_tx = 8'h00; m_wp = 1'b0; m_err = 1'b0; m_abort = 1'b0; m_ovr = 1'b0;
        m_fcnt = 5'd0; m_pos = 0; m_op = 8'h00; m_n = 8'h00; m_addr = 4'h0;
    endtask

    task automatic consume(input logic [7:0] b);
        int k;
        logic [3:0] a;
        if (m_pos == 0) begin
            m_op = b;
            if (b == 8'h01 || b == 8'h02) m_tx = 8'hA5;
            else if (b == 8'h03) begin
                m_tx = m_status(); m_err = 1'b0; m_abort = 1'b0; m_ovr = 1'b0;
            end else begin
                m_tx = 8'hEE; m_err = 1'b1;
            end
        end else if (!(m_op inside {8'h01, 8'h02, 8'h03})) begin
            m_tx = 8'hEE;
        end else if (m_op == 8'h03) begin
            m_ovr = 1'b1; m_tx = 8'h00;
        end else if (m_pos == 1) begin
            m_addr = b[3:0]; m_tx = m_status();
        end else if (m_pos == 2) begin
            m_n = b;
            if (b == 8'h00) begin
                m_tx = 8'h00;
                if (m_op == 8'h01) m_fcnt = m_fcnt + 5'd1;
            end else begin
                m_tx = (m_op == 8'h01) ? 8'h00 : m_mem[m_addr];
            end
        end else begin
            k = m_pos - 3;
            if (k < int'(m_n)) begin
                a = m_addr + k[3:0];
                if (m_op == 8'h01) begin
                    m_mem[a] = b; m_wp = 1'b1; m_tx = 8'h00;
                    if (k == int'(m_n) - 1) m_fcnt = m_fcnt + 5'd1;
                end else begin
                    m_tx = m_mem[a + 4'd1];
                end
            end else begin
                m_ovr = 1'b1; m_tx = 8'h00;
            end
        end
        m_pos++;
    endtask

    task automatic model_edge(input logic cs, input logic vld, input logic [7:0] b);
        m_wp = 1'b0;
        if (!cs) begin
            if ((m_op == 8'h01 || m_op == 8'h02) && m_pos >= 1 &&
                !(m_pos >= 3 && m_pos >= 3 + int'(m_n))) m_abort = 1'b1;
            m_pos = 0;
            m_op  = 8'h00;
        end else if (vld) begin
            consume(b);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge sclk) begin
        chk("cyc_tx_byte", tx_byte, m_tx);
        chk("cyc_status", status, m_status());
        chk("cyc_wr_pulse", {7'b0, wr_pulse}, {7'b0, m_wp});
        chk("cyc_rd_data", rd_data, m_mem[rd_addr]);
    end

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic cyc(input logic cs, input logic vld, input logic [7:0] b);
        cs_active = cs; rx_valid = vld; rx_byte = b; rd_addr = 4'($urandom);
        @(posedge sclk);
        model_edge(cs, vld, b);
        #1;
        $display("cyc cs=%0b vld=%0b rx=%h tx=%h st=%h wp=%0b", cs, vld, b, tx_byte, status, wr_pulse);
    endtask

    task automatic send(input logic [7:0] b, input int exp_tx, input int gaps);
        cyc(1'b1, 1'b1, b);
        if (exp_tx >= 0) chk("lit_tx", tx_byte, 8'(exp_tx));
        for (int g = 0; g < gaps; g++) cyc(1'b1, 1'b0, 8'($urandom));
    endtask

    task automatic end_frame();
        cyc(1'b0, 1'($urandom), 8'($urandom));
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic peek(input string name, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        rst_L = 1'b0; cs_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rd_addr = 4'h0;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_status", status, 8'h00);
        rst_L = 1'b1;
        end_frame();

        // WRITE 01,03,02,11,22
        send(8'h01, 8'hA5, 1);
        send(8'h03, 8'h00, 0);
        send(8'h02, 8'h00, 2);
        send(8'h11, 8'h00, 0);
        chk("t1_wp0", {7'b0, wr_pulse}, 8'h01);
        send(8'h22, 8'h00, 1);
        end_frame();
        peek("t1_mem3", 4'h3, 8'h11);
        peek("t1_mem4", 4'h4, 8'h22);
        chk("t1_status", status, 8'h01);

        // READ 02,03,02,xx,xx
        send(8'h02, 8'hA5, 0);
        send(8'h03, 8'h01, 1);
        send(8'h02, 8'h11, 0);
        send(8'h5C, 8'h22, 2);
        send(8'h9D, 8'h00, 0);
        end_frame();

        // WRITE wrapping past the top address
        send(8'h01, 8'hA5, 0);
        send(8'h0F, 8'h01, 0);
        send(8'h03, 8'h00, 0);
        send(8'hAA, 8'h00, 0);
        send(8'hBB, 8'h00, 1);
        send(8'hCC, 8'h00, 0);
        end_frame();
        peek("t3_memF", 4'hF, 8'hAA);
        peek("t3_mem0", 4'h0, 8'hBB);
        peek("t3_mem1", 4'h1, 8'hCC);
        chk("t3_status", status, 8'h02);

        // Invalid opcode, then STATUS read clears the error
        send(8'h7F, 8'hEE, 0);
        send(8'h12, 8'hEE, 1);
        send(8'h34, 8'hEE, 0);
        chk("t4_err", status, 8'h82);
        end_frame();
        send(8'h03, 8'h82, 0);
        chk("t4_clr", status, 8'h02);
        end_frame();

        // Abort after one data byte
        send(8'h01, 8'hA5, 0);
        send(8'h02, 8'h02, 0);
        send(8'h05, 8'h00, 0);
        send(8'h5A, 8'h00, 0);
        end_frame();
        chk("t5_abort", status, 8'h42);
        peek("t5_mem2", 4'h2, 8'h5A);

        // Asynchronous reset in the middle of a WRITE data phase
        send(8'h01, 8'hA5, 0);
        send(8'h08, 8'h42, 0);
        send(8'h04, 8'h00, 0);
        send(8'h77, 8'h00, 0);
        #2;
        rst_L = 1'b0; rx_valid = 1'b0;
        model_reset();
        #1;
        chk("t6_tx", tx_byte, 8'h00);
        chk("t6_status", status, 8'h00);
        chk("t6_wp", {7'b0, wr_pulse}, 8'h00);
        peek("t6_mem8", 4'h8, 8'h00);
        peek("t6_mem3", 4'h3, 8'h00);
        @(posedge sclk);
        #1;
        rst_L = 1'b1;
        send(8'h02, 8'hA5, 0);
        send(8'h03, 8'h00, 0);
        send(8'h01, 8'h00, 0);
        send(8'hFF, 8'h00, 0);
        end_frame();

        // Random frames, including truncated ones and overrun bytes
        for (int f = 0; f < 300; f++) begin
            int r, len, nb;
            logic [7:0] fr [$];
            r = $urandom_range(0, 9);
            fr.delete();
            if (r <= 3)      fr.push_back(8'h01);
            else if (r <= 6) fr.push_back(8'h02);
            else if (r == 7) fr.push_back(8'h03);
            else             fr.push_back(8'($urandom));
            fr.push_back(8'($urandom));
            len = $urandom_range(0, 6);
            fr.push_back(8'(len));
            for (int i = 0; i < len + 2; i++) fr.push_back(8'($urandom));
            nb = $urandom_range(1, fr.size());
            for (int i = 0; i < nb; i++) send(fr[i], -1, $urandom_range(0, 2));
            end_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
